// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - time-multiplexed multi-digit hex 7-segment driver
// Captures a hex word on load and scans it across DIGITS positions, one DIV-cycle slot each.
module hex_scan_display #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  slot_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   sh_val;
  logic [DIGITS-1:0]     sh_dp;
  logic                  tick;

  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank;
  logic                  run;
  logic [DIGITS-1:0]     oh;
  logic [6:0]            lit;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [DIGITS-1:0]     an_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  assign tick = (pcnt == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt      <= '0;
      idx       <= '0;
      slot_tick <= 1'b0;
    end else begin
      slot_tick <= tick;
      pcnt      <= tick ? '0 : pcnt + PW'(1);
      if (tick) begin
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val <= '0;
      sh_dp  <= '0;
    end else if (load) begin
      sh_val <= value;
      sh_dp  <= dp;
    end
  end

  // Walk from the top digit down so run means "this nibble and all above are zero".
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    oh     = '0;
    run    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run & (sh_val[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        nib    = sh_val[4*k +: 4];
        dp_sel = sh_dp[k];
        oh[k]  = 1'b1;
        blank  = blank_lz && (k != 0) && run;
      end
    end
    lit   = blank ? 7'b0000000 : glyph(nib);
    seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_sel : dp_sel;
    an_d  = AN_ACTIVE_LOW ? ~oh : oh;
  end

  // Segments, dp and anode share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_OFF;
      dp_n  <= DP_OFF;
      an    <= AN_OFF;
    end else begin
      seg_n <= seg_d;
      dp_n  <= dp_d;
      an    <= an_d;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// tb/tb_hex_scan_display.sv - scoreboard bench for hex_scan_display
// Three configurations share one stimulus stream; a reference model feeds per-instance queues.
module tb_hex_scan_display;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       tick;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;

  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [3:0] an0, an1;
  logic [0:0] an2;
  logic       tk0, tk1, tk2;

  int total = 0;
  int bad   = 0;

  out_t q0[$];
  out_t q1[$];
  out_t q2[$];

  int          cnt;
  logic [15:0] msv;
  logic [3:0]  msd;
  logic        rst_was;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  hex_scan_display #(.DIGITS(4), .DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load), .blank_lz(blank_lz),
    .seg_n(seg0), .dp_n(dp0), .an(an0), .slot_tick(tk0));

  hex_scan_display #(.DIGITS(4), .DIV(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load), .blank_lz(blank_lz),
    .seg_n(seg1), .dp_n(dp1), .an(an1), .slot_tick(tk1));

  hex_scan_display #(.DIGITS(1), .DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .value(value[3:0]), .dp(dp[0:0]), .load(load), .blank_lz(blank_lz),
    .seg_n(seg2), .dp_n(dp2), .an(an2), .slot_tick(tk2));

  function automatic out_t off_state(input bit sal, input bit aal, input int digits);
    out_t r;
    r.seg  = sal ? 7'h7F : 7'h00;
    r.dp   = sal;
    r.an   = aal ? 8'((1 << digits) - 1) : 8'h00;
    r.tick = 1'b0;
    return r;
  endfunction

  // cc = rising edges completed since reset release; digit shown = (cc/div) mod digits.
  function automatic out_t model(input int digits, input int div, input bit sal, input bit aal,
                                 input int cc, input logic [15:0] sv, input logic [3:0] sd,
                                 input logic blz);
    out_t r;
    int k;
    int full;
    int nib;
    logic [6:0] g;
    logic [7:0] oh;
    logic [7:0] amask;
    logic dl;
    k     = (cc / div) % digits;
    full  = int'(sv) & ((1 << (4 * digits)) - 1);
    nib   = (full >> (4 * k)) & 15;
    g     = (blz && k > 0 && (full >> (4 * k)) == 0) ? 7'h00 : glyph_tab[nib];
    dl    = sd[k];
    oh    = 8'(1 << k);
    amask = 8'((1 << digits) - 1);
    r.seg  = sal ? ~g : g;
    r.dp   = sal ? ~dl : dl;
    r.an   = aal ? (~oh & amask) : oh;
    r.tick = ((cc % div) == div - 1);
    return r;
  endfunction

  task automatic cmp(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b",
               name, $time, act.seg, act.dp, act.an, act.tick, exp.seg, exp.dp, exp.an, exp.tick);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (q0.size() > 0) cmp("dut0", out_t'({seg0, dp0, 4'b0000, an0, tk0}), q0.pop_front());
    if (q1.size() > 0) cmp("dut1", out_t'({seg1, dp1, 4'b0000, an1, tk1}), q1.pop_front());
    if (q2.size() > 0) cmp("dut2", out_t'({seg2, dp2, 7'b0000000, an2, tk2}), q2.pop_front());
  end

  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d,
                      input logic b);
    @(negedge clk);
    rst_n    = r;
    load     = l;
    value    = v;
    dp       = d;
    blank_lz = b;
    if (!r) begin
      if (rst_was) begin
        #1;
        cmp("async_rst0", out_t'({seg0, dp0, 4'b0000, an0, tk0}), off_state(1, 1, 4));
        cmp("async_rst1", out_t'({seg1, dp1, 4'b0000, an1, tk1}), off_state(0, 0, 4));
      end
      cnt = 0;
      msv = '0;
      msd = '0;
      q0.push_back(off_state(1, 1, 4));
      q1.push_back(off_state(0, 0, 4));
      q2.push_back(off_state(1, 1, 1));
    end else begin
      q0.push_back(model(4, 4, 1, 1, cnt, msv, msd, b));
      q1.push_back(model(4, 1, 0, 0, cnt, msv, msd, b));
      q2.push_back(model(1, 1, 1, 1, cnt, msv, msd, b));
      cnt++;
      if (l) begin
        msv = v;
        msd = d;
      end
    end
    rst_was = r;
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 4'h0, b);
  endtask

  initial begin
    logic        b;
    logic [15:0] v;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp       = '0;
    blank_lz = 1'b0;
    cnt      = 0;
    msv      = '0;
    msd      = '0;
    rst_was  = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(5, 1'b0);

    step(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    idle(20, 1'b0);

    step(1'b1, 1'b1, 16'h0050, 4'h0, 1'b1);
    idle(16, 1'b1);
    idle(8, 1'b0);
    step(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
    idle(16, 1'b1);

    step(1'b1, 1'b1, 16'h00A0, 4'b0100, 1'b1);
    idle(16, 1'b1);

    for (int n = 0; n < 16; n++) step(1'b1, 1'b1, {12'(n * 273), 4'(n)}, 4'(n), 1'b0);
    idle(2, 1'b0);

    step(1'b1, 1'b1, 16'h9876, 4'b1010, 1'b0);
    while (cnt % 16 != 10) idle(1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(12, 1'b0);

    step(1'b1, 1'b1, 16'h4321, 4'h0, 1'b0);
    while (cnt % 4 != 3) idle(1, 1'b0);
    step(1'b1, 1'b1, 16'hBEEF, 4'b0010, 1'b0);
    idle(8, 1'b0);

    b = 1'b0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 3)
        0: v = 16'($urandom);
        1: v = 16'($urandom) & 16'h00FF;
        default: v = 16'($urandom) & 16'h000F;
      endcase
      if ($urandom % 20 == 0) b = ~b;
      step(1'b1, ($urandom % 6) == 0, v, 4'($urandom), b);
    end

    idle(2, b);
    @(posedge clk);
    #4;
    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
